// File: rtl/adder_accum_ctrl_pkg.sv
// Shared types, default width and helper functions for the adder/accumulator controller.
package adder_accum_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Two's-complement overflow: operands share a sign but the result's sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder16.sv
// Combinational carry-lookahead adder: every carry is formed directly from
// generate/propagate terms and the carry-in, with no ripple chain.
module adder16
    import adder_accum_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH-1:0] gen_s;
    logic [WIDTH-1:0] prop_s;
    logic [WIDTH:0]   carry_s;

    // Expand each carry as g[i] | p[i]g[i-1] | ... | p[i..0]Cin and form the sum.
    always_comb begin
        gen_s   = A & B;
        prop_s  = A ^ B;
        carry_s = '0;
        carry_s[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            logic term_c;
            logic prod_p;
            term_c = gen_s[i];
            prod_p = prop_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                term_c = term_c | (prod_p & gen_s[j]);
                prod_p = prod_p & prop_s[j];
            end
            carry_s[i+1] = term_c | (prod_p & Cin);
        end
        S    = prop_s ^ carry_s[WIDTH-1:0];
        Cout = carry_s[WIDTH];
    end

endmodule

// File: rtl/adder_accum_ctrl.sv
// Push-button driven accumulator: ClearA_LoadB clears A and loads B from SW,
// Run adds B into A once per press. Buttons are synchronized and each press
// performs exactly one action until both buttons are released.
module adder_accum_ctrl
    import adder_accum_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OVF,
    output logic             Done
);

    logic [1:0]       run_sync_r;
    logic [1:0]       clr_sync_r;
    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] add_s;
    logic             add_co_s;

    adder16 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (a_r),
        .B    (b_r),
        .Cin  (1'b0),
        .S    (add_s),
        .Cout (add_co_s)
    );

    // Two-flop synchronizers for the raw button levels.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_sync_r <= 2'b00;
            clr_sync_r <= 2'b00;
        end else begin
            run_sync_r <= {run_sync_r[0], Run};
            clr_sync_r <= {clr_sync_r[0], ClearA_LoadB};
        end
    end

    // Control state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; load wins over run, hold waits for both buttons released.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_sync_r[1]) begin
                    state_s = ST_LOAD;
                end else if (run_sync_r[1]) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: state_s = ST_HOLD;
            ST_EXEC: state_s = ST_HOLD;
            ST_HOLD: begin
                if (!run_sync_r[1] && !clr_sync_r[1]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Operand and result registers; results change only when an add executes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_r <= '0;
            b_r <= '0;
            Sum <= '0;
            CO  <= 1'b0;
            OVF <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    a_r <= '0;
                    b_r <= SW;
                end
                ST_EXEC: begin
                    a_r <= add_s;
                    Sum <= add_s;
                    CO  <= add_co_s;
                    OVF <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], add_s[WIDTH-1]);
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    // Done is registered from the next state so it is high exactly while in HOLD.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Done <= 1'b0;
        end else begin
            Done <= (state_s == ST_HOLD);
        end
    end

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Self-checking bench for adder_accum_ctrl: directed button sequences plus
// randomized presses, compared against an arithmetic model of the accumulator.
module tb_adder_accum_ctrl;

    localparam int W = 16;

    logic         Clk;
    logic         Reset;
    logic         Run;
    logic         ClearA_LoadB;
    logic [W-1:0] SW;
    logic [W-1:0] Sum;
    logic         CO;
    logic         OVF;
    logic         Done;

    // standalone adder instance for direct operand checks
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         tcin;
    logic [W-1:0] ts;
    logic         tco;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W-1:0] m_sum;
    logic         m_co;
    logic         m_ovf;

    adder_accum_ctrl #(
        .WIDTH (W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .SW           (SW),
        .Sum          (Sum),
        .CO           (CO),
        .OVF          (OVF),
        .Done         (Done)
    );

    adder16 #(
        .WIDTH (W)
    ) u_add_chk (
        .A    (ta),
        .B    (tb),
        .Cin  (tcin),
        .S    (ts),
        .Cout (tco)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic exp_done);
        check_value({tag, "_sum"}, 32'(Sum), 32'(m_sum));
        check_value({tag, "_co"}, 32'(CO), 32'(m_co));
        check_value({tag, "_ovf"}, 32'(OVF), 32'(m_ovf));
        check_value({tag, "_done"}, 32'(Done), 32'(exp_done));
    endtask

    // Model of one button action: load clears A and takes B, run adds B into A.
    task automatic model_action(input logic do_run, input logic do_clr, input logic [W-1:0] sw_val);
        longint unsigned u;
        longint          ss;
        longint          lim;
        if (do_clr) begin
            m_a = '0;
            m_b = sw_val;
        end else if (do_run) begin
            u     = longint'(m_a) + longint'(m_b);
            m_sum = u[W-1:0];
            m_co  = u[W];
            ss    = longint'($signed(m_a)) + longint'($signed(m_b));
            lim   = longint'(1) <<< (W - 1);
            m_ovf = (ss > lim - 1) || (ss < -lim);
            m_a   = m_sum;
        end
    endtask

    // Press buttons (applied just after an edge), hold for hold_cyc edges, release
    // and wait for Done to fall. The action lands on the 4th edge after the press.
    task automatic press(input logic do_run, input logic do_clr, input logic [W-1:0] sw_val, input int hold_cyc);
        int n;
        SW           = sw_val;
        Run          = do_run;
        ClearA_LoadB = do_clr;
        for (int c = 1; c <= hold_cyc; c++) begin
            tick();
            if (c == 4) begin
                model_action(do_run, do_clr, sw_val);
                SW = W'($urandom);
            end
            check_outputs("hold", c >= 4);
        end
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        n = 0;
        while (Done && n < 8) begin
            tick();
            n++;
        end
        check_value("release_cycles", 32'(n), 32'd3);
        check_outputs("released", 1'b0);
        tick();
    endtask

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        SW           = '0;
        ta           = '0;
        tb           = '0;
        tcin         = 1'b0;
        m_a          = '0;
        m_b          = '0;
        m_sum        = '0;
        m_co         = 1'b0;
        m_ovf        = 1'b0;
        #2;
        check_outputs("reset", 1'b0);
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // load 3, then three runs: 3, 6, 9 with SW wandering meanwhile
        press(1'b0, 1'b1, 16'h0003, 5);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, W'($urandom), 5);
        check_value("acc_three", 32'(Sum), 32'h0009);

        // -1 + -1 wraps with carry and no signed overflow
        press(1'b0, 1'b1, 16'hFFFF, 4);
        press(1'b1, 1'b0, 16'h0000, 4);
        press(1'b1, 1'b0, 16'h1234, 4);
        check_value("wrap_sum", 32'(Sum), 32'h0000FFFE);
        check_value("wrap_co", 32'(CO), 32'd1);

        // 0x4000 + 0x4000 overflows into the sign bit
        press(1'b0, 1'b1, 16'h4000, 4);
        press(1'b1, 1'b0, 16'hAAAA, 4);
        press(1'b1, 1'b0, 16'h5555, 4);
        check_value("ovf_sum", 32'(Sum), 32'h8000);
        check_value("ovf_flag", 32'(OVF), 32'd1);

        // adder used directly: 0xFFFF + 0x0001 and random operands
        ta = 16'hFFFF; tb = 16'h0001; tcin = 1'b0; #1;
        check_value("adder_wrap_s", 32'(ts), 32'h0000);
        check_value("adder_wrap_co", 32'(tco), 32'd1);
        for (int i = 0; i < 16; i++) begin
            logic [W:0] ref_sum;
            ta = W'($urandom); tb = W'($urandom); tcin = 1'($urandom);
            #1;
            ref_sum = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};
            check_value("adder_rand", 32'({tco, ts}), 32'(ref_sum));
        end

        // long hold: one add only
        press(1'b1, 1'b0, W'($urandom), 20);

        // simultaneous buttons: load wins, Sum unchanged, then one run gives B
        press(1'b1, 1'b1, 16'h0101, 6);
        press(1'b1, 1'b0, W'($urandom), 4);
        check_value("after_both", 32'(Sum), 32'h0101);

        // randomized presses
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [W-1:0] v;
            kind = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0: v = 16'h7FFF;
                1: v = 16'h8000;
                2: v = 16'hFFFF;
                default: v = W'($urandom);
            endcase
            if (kind < 2)       press(1'b0, 1'b1, v, int'($urandom_range(4, 9)));
            else if (kind == 2) press(1'b1, 1'b1, v, int'($urandom_range(4, 9)));
            else                press(1'b1, 1'b0, v, int'($urandom_range(4, 9)));
        end

        // reset while EXEC is active clears everything before the next edge
        press(1'b0, 1'b1, 16'h1234, 4);
        press(1'b1, 1'b0, 16'h0000, 4);
        Run = 1'b1;
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        m_a = '0; m_b = '0; m_sum = '0; m_co = 1'b0; m_ovf = 1'b0;
        check_outputs("async_reset", 1'b0);
        repeat (2) tick();
        // Run still held after reset release counts as a new request
        Reset = 1'b0;
        press(1'b1, 1'b0, W'($urandom), 6);
        press(1'b0, 1'b1, 16'h0042, 4);
        press(1'b1, 1'b0, W'($urandom), 4);
        check_value("post_reset", 32'(Sum), 32'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
